// File: rtl/mem_port_arbiter_if.sv
// Per-master memory port bundle shared by the CPU and the I/O / loader engine.
//
// master modport : the requesting side (CPU or loader engine)
//   req    - request, held until gnt
//   cmd    - 01 MREAD, 10 MWRITE (00/11 mean no request)
//   addr   - memory address
//   wdata  - write data
//   lock   - keep ownership of the port after the current beat
//   gnt    - one-cycle accept pulse (combinational in the accept cycle)
//   rvalid - one-cycle pulse, rdata valid
//   rdata  - read data returned to this master
// slave modport  : the arbiter side of the same signals
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, cmd, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, cmd, addr, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single synchronous RAM port.
// Master 0 is the CPU, master 1 is the I/O / program-loader engine.
// Round-robin per transaction, with an optional lock that lets the granted
// master keep the port for back-to-back beats. Memory commands are
// registered (they appear one cycle after gnt) and read data is routed back
// to the issuing master through a tagged return shift register.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   m0, m1     - master ports (mem_port_arbiter_if.slave)
//   mem_cmd    - 00 MNONE, 01 MREAD, 10 MWRITE (registered)
//   mem_addr   - memory address (registered)
//   mem_wdata  - memory write data (registered)
//   mem_rdata  - memory read data, READ_LAT cycles after MREAD
//   busy       - a read is in flight or a lock is held
module mem_port_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    m0,
    mem_port_arbiter_if.slave    m1,
    output logic [1:0]           mem_cmd,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    // Only MREAD and MWRITE count as a request; 00/11 are ignored.
    function automatic logic cmd_is_valid(input logic [1:0] c);
        return (c == MREAD) || (c == MWRITE);
    endfunction

    state_t              state_r;
    logic                rr_ptr_r;      // 0: master 0 wins a tie, 1: master 1

    logic                m0_valid_s;
    logic                m1_valid_s;
    logic                gnt0_s;
    logic                gnt1_s;
    logic                any_gnt_s;
    logic [1:0]          sel_cmd_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    logic [1:0]          mem_cmd_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;

    // Return pipe: stage 0 lines up with mem_cmd, stage READ_LAT with mem_rdata.
    logic [READ_LAT:0]   ret_vld_r;
    logic [READ_LAT:0]   ret_id_r;

    logic                m0_rvalid_s;
    logic                m1_rvalid_s;
    logic [DATA_W-1:0]   m0_hold_r;
    logic [DATA_W-1:0]   m1_hold_r;

    assign m0_valid_s = m0.req && cmd_is_valid(m0.cmd);
    assign m1_valid_s = m1.req && cmd_is_valid(m1.cmd);

    // Grant decision for the current cycle; suppressed while reset is asserted.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m0_valid_s && m1_valid_s) begin
                        gnt0_s = ~rr_ptr_r;
                        gnt1_s = rr_ptr_r;
                    end else begin
                        gnt0_s = m0_valid_s;
                        gnt1_s = m1_valid_s;
                    end
                end
                ST_OWN0: begin
                    gnt0_s = m0_valid_s;
                    gnt1_s = 1'b0;
                end
                ST_OWN1: begin
                    gnt0_s = 1'b0;
                    gnt1_s = m1_valid_s;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    assign any_gnt_s = gnt0_s | gnt1_s;

    // Mux the winning master's beat towards the memory command registers.
    always_comb begin
        sel_cmd_s   = m0.cmd;
        sel_addr_s  = m0.addr;
        sel_wdata_s = m0.wdata;
        if (gnt1_s) begin
            sel_cmd_s   = m1.cmd;
            sel_addr_s  = m1.addr;
            sel_wdata_s = m1.wdata;
        end else begin
            sel_cmd_s   = m0.cmd;
            sel_addr_s  = m0.addr;
            sel_wdata_s = m0.wdata;
        end
    end

    // Ownership FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= 1'b0;
        end else begin
            // Every grant, locked or not, hands priority to the other master.
            if (any_gnt_s) begin
                rr_ptr_r <= gnt0_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (gnt0_s && m0.lock) begin
                        state_r <= ST_OWN0;
                    end else if (gnt1_s && m1.lock) begin
                        state_r <= ST_OWN1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OWN0: begin
                    // The releasing beat (lock=0) is still granted this cycle.
                    if (!m0.req || !m0.lock) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OWN1: begin
                    if (!m1.req || !m1.lock) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered memory command; address and data hold between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_cmd_r   <= MNONE;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (any_gnt_s) begin
            mem_cmd_r   <= sel_cmd_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
        end else begin
            mem_cmd_r   <= MNONE;
        end
    end

    // Tagged return pipe: one entry per issued read, id = issuing master.
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_vld_r <= {(READ_LAT+1){1'b0}};
            ret_id_r  <= {(READ_LAT+1){1'b0}};
        end else begin
            ret_vld_r <= {ret_vld_r[READ_LAT-1:0], any_gnt_s && (sel_cmd_s == MREAD)};
            ret_id_r  <= {ret_id_r[READ_LAT-1:0], gnt1_s};
        end
    end

    assign m0_rvalid_s = ret_vld_r[READ_LAT] & ~ret_id_r[READ_LAT];
    assign m1_rvalid_s = ret_vld_r[READ_LAT] &  ret_id_r[READ_LAT];

    // Last returned read data per master, shown while rvalid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_hold_r <= {DATA_W{1'b0}};
            m1_hold_r <= {DATA_W{1'b0}};
        end else begin
            if (m0_rvalid_s) begin
                m0_hold_r <= mem_rdata;
            end
            if (m1_rvalid_s) begin
                m1_hold_r <= mem_rdata;
            end
        end
    end

    assign m0.gnt    = gnt0_s;
    assign m1.gnt    = gnt1_s;
    assign m0.rvalid = m0_rvalid_s;
    assign m1.rvalid = m1_rvalid_s;
    // RAM data arrives in the rvalid cycle itself, so pass it straight through then.
    assign m0.rdata  = m0_rvalid_s ? mem_rdata : m0_hold_r;
    assign m1.rdata  = m1_rvalid_s ? mem_rdata : m1_hold_r;

    assign mem_cmd   = mem_cmd_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = (state_r != ST_IDLE) || (|ret_vld_r);

endmodule
